// File: rtl/ram_io_responder_pkg.sv
// Shared constants and types for the RAM/IO responder.
//  - RAM_IO_PORT / RAM_HALT_PORT : special byte addresses decoded ahead of the RAM.
//  - READ_SIT / WRITE_SIT        : encoding of the controller's rw flag (1 = read).
//  - acc_kind_e / decode_addr    : classification of an incoming address.
package ram_io_responder_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [7:0]  byte_t;

    localparam addr_t RAM_IO_PORT   = 32'h0003_0000;
    localparam addr_t RAM_HALT_PORT = 32'h0003_0004;
    localparam logic  READ_SIT      = 1'b1;
    localparam logic  WRITE_SIT     = 1'b0;

    typedef enum logic [1:0] {
        ACC_RAM  = 2'd0,
        ACC_IO   = 2'd1,
        ACC_HALT = 2'd2
    } acc_kind_e;

    // The full 32-bit address is compared for the ports; everything else is RAM.
    function automatic acc_kind_e decode_addr(input addr_t a);
        if (a == RAM_IO_PORT) begin
            return ACC_IO;
        end
        if (a == RAM_HALT_PORT) begin
            return ACC_HALT;
        end
        return ACC_RAM;
    endfunction

endpackage

// File: rtl/ram_io_responder_if.sv
// Byte-wide RAM port between the memory controller (master) and the responder (slave).
//  rw_flag_in     : 1 = read, 0 = write
//  addr_in        : byte address
//  data_in        : write byte
//  data_out       : registered read byte
//  io_buffer_full : TX FIFO near full, controller stalls I/O accesses
interface ram_io_responder_if;
    import ram_io_responder_pkg::*;

    logic  rw_flag_in;
    addr_t addr_in;
    byte_t data_in;
    byte_t data_out;
    logic  io_buffer_full;

    modport master (
        output rw_flag_in, addr_in, data_in,
        input  data_out, io_buffer_full
    );

    modport slave (
        input  rw_flag_in, addr_in, data_in,
        output data_out, io_buffer_full
    );

endinterface

// File: rtl/ram_io_responder_byte_fifo.sv
// Byte FIFO with occupancy count and a registered near-full flag.
//  clk_in/rst_in : clock, asynchronous active-high reset
//  push/din      : enqueue din (caller guarantees not full, or pop in the same cycle)
//  pop           : dequeue head (caller guarantees not empty)
//  head          : oldest entry
//  count         : occupancy, 0..DEPTH
//  near_full     : (DEPTH - count) <= MARGIN, computed from the post-update count
module byte_fifo #(
    parameter int DEPTH  = 16,
    parameter int MARGIN = 2
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   push,
    input  logic                   pop,
    input  logic [7:0]             din,
    output logic [7:0]             head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   near_full
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [7:0]       buf_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             near_full_q, near_full_d;

    // Pointers are PTR_W bits wide, so increment wraps modulo DEPTH for free.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        near_full_d = (DEPTH - int'(count_d)) <= MARGIN;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            near_full_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            near_full_q <= near_full_d;
        end
    end

    // Storage carries no reset. On push+pop while full, wr_ptr == rd_ptr: the old
    // head is read out combinationally this cycle and overwritten at the edge.
    always_ff @(posedge clk_in) begin
        if (push) begin
            buf_mem[wr_ptr_q] <= din;
        end
    end

    assign head      = buf_mem[rd_ptr_q];
    assign count     = count_q;
    assign near_full = near_full_q;

endmodule

// File: rtl/ram_io_responder.sv
// Memory-side responder for the controller's byte-wide RAM port.
//  clk_in, rst_in (async, active-high), rdy_in (low freezes all state)
//  bus      : controller port (rw flag, address, write byte, read byte, io_buffer_full)
//  tx_*     : console-out byte stream drained from the TX FIFO
//  rx_*     : console-in byte stream, rx_pop pulses when a byte is consumed
//  tx_overflow / sim_halt : sticky status flags
// Ordinary addresses hit a byte RAM (one-cycle read latency); RAM_IO_PORT maps to
// the TX FIFO (writes) and the RX stream (reads); RAM_HALT_PORT writes raise sim_halt.
module ram_io_responder
    import ram_io_responder_pkg::*;
#(
    parameter int ADDR_WIDTH  = 17,
    parameter int TX_DEPTH    = 16,
    parameter int FULL_MARGIN = 2
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      rdy_in,
    ram_io_responder_if.slave         bus,
    output logic [7:0]                tx_data,
    output logic                      tx_valid,
    input  logic                      tx_ready,
    input  logic [7:0]                rx_data,
    input  logic                      rx_valid,
    output logic                      rx_pop,
    output logic                      tx_overflow,
    output logic                      sim_halt
);
    acc_kind_e               kind;
    logic                    is_read, is_write;
    logic [ADDR_WIDTH-1:0]   idx;

    logic [7:0]              mem [2**ADDR_WIDTH];
    byte_t                   ram_rd_q;

    // data_out is a mux between the RAM read register and a small I/O result
    // register. ram_sel_q resetting to 0 is what discards an in-flight RAM read.
    logic                    ram_sel_q, ram_sel_d;
    byte_t                   io_rd_q, io_rd_d;
    logic                    tx_overflow_q, tx_overflow_d;
    logic                    sim_halt_q, sim_halt_d;

    logic                    fifo_push, fifo_pop, fifo_full, fifo_near_full;
    logic [$clog2(TX_DEPTH):0] fifo_count;

    always_comb begin
        kind      = decode_addr(bus.addr_in);
        idx       = bus.addr_in[ADDR_WIDTH-1:0];
        is_read   = rdy_in && (bus.rw_flag_in == READ_SIT);
        is_write  = rdy_in && (bus.rw_flag_in == WRITE_SIT);

        fifo_full = (fifo_count == ($clog2(TX_DEPTH)+1)'(TX_DEPTH));
        fifo_pop  = rdy_in && tx_valid && tx_ready;
        // A concurrent pop frees a slot, so a push into a full FIFO still lands.
        fifo_push = is_write && (kind == ACC_IO) && (!fifo_full || fifo_pop);
        rx_pop    = !rst_in && is_read && (kind == ACC_IO) && rx_valid;

        ram_sel_d     = ram_sel_q;
        io_rd_d       = io_rd_q;
        tx_overflow_d = tx_overflow_q;
        sim_halt_d    = sim_halt_q;

        if (rdy_in) begin
            ram_sel_d = is_read && (kind == ACC_RAM);
            // Writes, HALT reads and empty IO reads all return zero.
            io_rd_d   = (is_read && (kind == ACC_IO) && rx_valid) ? rx_data : 8'h00;
        end
        if (is_write && (kind == ACC_IO) && fifo_full && !fifo_pop) begin
            tx_overflow_d = 1'b1;
        end
        if (is_write && (kind == ACC_HALT)) begin
            sim_halt_d = 1'b1;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            ram_sel_q     <= 1'b0;
            io_rd_q       <= 8'h00;
            tx_overflow_q <= 1'b0;
            sim_halt_q    <= 1'b0;
        end else begin
            ram_sel_q     <= ram_sel_d;
            io_rd_q       <= io_rd_d;
            tx_overflow_q <= tx_overflow_d;
            sim_halt_q    <= sim_halt_d;
        end
    end

    // Byte RAM with registered read; kept free of reset so it maps onto block RAM.
    always_ff @(posedge clk_in) begin
        if (is_write && (kind == ACC_RAM)) begin
            mem[idx] <= bus.data_in;
        end
        if (is_read && (kind == ACC_RAM)) begin
            ram_rd_q <= mem[idx];
        end
    end

    byte_fifo #(
        .DEPTH  (TX_DEPTH),
        .MARGIN (FULL_MARGIN)
    ) u_tx_fifo (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .push      (fifo_push),
        .pop       (fifo_pop),
        .din       (bus.data_in),
        .head      (tx_data),
        .count     (fifo_count),
        .near_full (fifo_near_full)
    );

    assign tx_valid           = (fifo_count != '0);
    assign bus.data_out       = ram_sel_q ? ram_rd_q : io_rd_q;
    assign bus.io_buffer_full = fifo_near_full;
    assign tx_overflow        = tx_overflow_q;
    assign sim_halt           = sim_halt_q;

endmodule
